// File: rtl/register_shift_pkg.sv
// Shared definitions for the register_shift_n block: operation mode encodings.
package register_shift_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_LOAD = 2'b01,
      MODE_SRA  = 2'b10,
      MODE_SL   = 2'b11
   } mode_e;

endpackage : register_shift_pkg

// File: rtl/shift_step_counter.sv
// Saturating count of accepted shifts since the last load.
// The done output is a combinational decode of the registered count.
module shift_step_counter #(
   parameter  int unsigned STEPS = 32,
   localparam int unsigned CW    = $clog2(STEPS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          done
);

   logic [CW-1:0] count_q, count_d;

   assign count = count_q;
   assign done  = (count_q == CW'(STEPS));

   // Next count: clear on load, otherwise step until STEPS is reached.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !done) begin
         count_d = count_q + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : shift_step_counter

// File: rtl/register_shift_n.sv
// WIDTH-bit product/remainder register with hold, load, arithmetic shift
// right and shift left, plus a saturating shift-step counter and done flag.
// Build option: define REGISTER_SHIFT_ROTATE_EN to make shift left a rotate
// (fill = old MSB) instead of a logical shift filled from serial_in.
module register_shift_n
   import register_shift_pkg::*;
#(
   parameter  int unsigned WIDTH = 64,
   parameter  int unsigned STEPS = 32,
   localparam int unsigned CW    = $clog2(STEPS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] data_writeReg,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_readReg,
   output logic             serial_out,
   output logic [CW-1:0]    shift_count,
   output logic             done
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             sout_q, sout_d;
   logic             clr, inc;
   logic             fill;
   mode_e            mode_sel;

   assign mode_sel     = mode_e'(mode);
   assign data_readReg = data_q;
   assign serial_out   = sout_q;

`ifdef REGISTER_SHIFT_ROTATE_EN
   assign fill = data_q[WIDTH-1];
`else
   assign fill = serial_in;
`endif

   // Data path next state; shifts are dropped once done is high.
   always_comb begin
      data_d = data_q;
      sout_d = sout_q;
      clr    = 1'b0;
      inc    = 1'b0;
      case (mode_sel)
         MODE_LOAD: begin
            data_d = data_writeReg;
            sout_d = 1'b0;
            clr    = 1'b1;
         end
         MODE_SRA: begin
            if (!done) begin
               data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
               sout_d = data_q[0];
               inc    = 1'b1;
            end
         end
         MODE_SL: begin
            if (!done) begin
               data_d = {data_q[WIDTH-2:0], fill};
               sout_d = data_q[WIDTH-1];
               inc    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Data and serial-out registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
         sout_q <= 1'b0;
      end else begin
         data_q <= data_d;
         sout_q <= sout_d;
      end
   end

   shift_step_counter #(
      .STEPS (STEPS)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .inc   (inc),
      .count (shift_count),
      .done  (done)
   );

endmodule : register_shift_n

// File: tb/tb_register_shift_n.sv
// Directed bench for register_shift_n: an 8-bit/4-step instance and a
// 64-bit/32-step instance sharing one clock.
module tb_register_shift_n;

   logic        clk = 1'b0;
   logic        reset;

   logic [1:0]  mode8;
   logic [7:0]  din8;
   logic        sin8;
   logic [7:0]  dout8;
   logic        sout8;
   logic [2:0]  cnt8;
   logic        done8;

   logic [1:0]  mode64;
   logic [63:0] din64;
   logic        sin64;
   logic [63:0] dout64;
   logic        sout64;
   logic [5:0]  cnt64;
   logic        done64;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   register_shift_n #(
      .WIDTH (8),
      .STEPS (4)
   ) dut8 (
      .clk           (clk),
      .reset         (reset),
      .mode          (mode8),
      .data_writeReg (din8),
      .serial_in     (sin8),
      .data_readReg  (dout8),
      .serial_out    (sout8),
      .shift_count   (cnt8),
      .done          (done8)
   );

   register_shift_n #(
      .WIDTH (64),
      .STEPS (32)
   ) dut64 (
      .clk           (clk),
      .reset         (reset),
      .mode          (mode64),
      .data_writeReg (din64),
      .serial_in     (sin64),
      .data_readReg  (dout64),
      .serial_out    (sout64),
      .shift_count   (cnt64),
      .done          (done64)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Drive one operation on the 8-bit instance, then sample just after the edge.
   task automatic step8(input logic [1:0] m, input logic [7:0] d, input logic s);
      @(negedge clk);
      mode8 = m;
      din8  = d;
      sin8  = s;
      @(posedge clk);
      #1;
      mode8 = 2'b00;
   endtask

   task automatic step64(input logic [1:0] m, input logic [63:0] d);
      @(negedge clk);
      mode64 = m;
      din64  = d;
      @(posedge clk);
      #1;
      mode64 = 2'b00;
   endtask

   initial begin
      reset  = 1'b0;
      mode8  = 2'b00; din8  = '0; sin8  = 1'b0;
      mode64 = 2'b00; din64 = '0; sin64 = 1'b0;
      #12;
      chk("rst_data", 64'(dout8), 64'h00);
      chk("rst_sout", 64'(sout8), 64'h0);
      chk("rst_cnt",  64'(cnt8),  64'h0);
      chk("rst_done", 64'(done8), 64'h0);
      @(negedge clk);
      reset = 1'b1;

      // Hold after reset keeps everything at zero.
      step8(2'b00, 8'hFF, 1'b1);
      chk("hold_data", 64'(dout8), 64'h00);
      chk("hold_cnt",  64'(cnt8),  64'h0);

      // Load then one arithmetic shift right.
      step8(2'b01, 8'h96, 1'b0);
      chk("load_data", 64'(dout8), 64'h96);
      step8(2'b10, 8'h00, 1'b0);
      chk("sra_data", 64'(dout8), 64'hCB);
      chk("sra_sout", 64'(sout8), 64'h0);
      chk("sra_cnt",  64'(cnt8),  64'h1);
      step8(2'b00, 8'h00, 1'b0);
      chk("hold_nocount", 64'(cnt8), 64'h1);

      // Load then shift left with serial_in = 0, then with serial_in = 1.
      step8(2'b01, 8'h96, 1'b0);
      chk("reload_cnt", 64'(cnt8), 64'h0);
      step8(2'b11, 8'h00, 1'b0);
`ifdef REGISTER_SHIFT_ROTATE_EN
      chk("sl_data", 64'(dout8), 64'h2D);
`else
      chk("sl_data", 64'(dout8), 64'h2C);
`endif
      chk("sl_sout", 64'(sout8), 64'h1);
      step8(2'b11, 8'h00, 1'b1);
`ifdef REGISTER_SHIFT_ROTATE_EN
      chk("sl2_data", 64'(dout8), 64'h5A);
`else
      chk("sl2_data", 64'(dout8), 64'h59);
`endif
      chk("sl2_sout", 64'(sout8), 64'h0);
      chk("sl2_cnt",  64'(cnt8),  64'h2);

      // Four shifts to done, fifth ignored, reload clears.
      step8(2'b01, 8'h81, 1'b0);
      step8(2'b10, 8'h00, 1'b0);
      chk("sat1_data", 64'(dout8), 64'hC0);
      chk("sat1_sout", 64'(sout8), 64'h1);
      step8(2'b10, 8'h00, 1'b0);
      step8(2'b10, 8'h00, 1'b0);
      chk("sat3_done", 64'(done8), 64'h0);
      step8(2'b10, 8'h00, 1'b0);
      chk("sat4_data", 64'(dout8), 64'hF8);
      chk("sat4_cnt",  64'(cnt8),  64'h4);
      chk("sat4_done", 64'(done8), 64'h1);
      step8(2'b10, 8'h00, 1'b0);
      chk("sat5_data", 64'(dout8), 64'hF8);
      chk("sat5_cnt",  64'(cnt8),  64'h4);
      chk("sat5_sout", 64'(sout8), 64'h0);
      step8(2'b11, 8'h00, 1'b1);
      chk("sat_sl_data", 64'(dout8), 64'hF8);
      step8(2'b01, 8'h05, 1'b0);
      chk("reld_data", 64'(dout8), 64'h05);
      chk("reld_cnt",  64'(cnt8),  64'h0);
      chk("reld_done", 64'(done8), 64'h0);

      // Asynchronous reset between edges.
      step8(2'b01, 8'h96, 1'b0);
      step8(2'b10, 8'h00, 1'b0);
      step8(2'b10, 8'h00, 1'b0);
      chk("pre_rst_data", 64'(dout8), 64'hE5);
      chk("pre_rst_sout", 64'(sout8), 64'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_data", 64'(dout8), 64'h00);
      chk("arst_sout", 64'(sout8), 64'h0);
      chk("arst_cnt",  64'(cnt8),  64'h0);
      @(negedge clk);
      reset = 1'b1;

      // 64-bit instance: 32 arithmetic shifts to done.
      step64(2'b01, 64'h8000_0000_0000_0001);
      chk("w64_load", dout64, 64'h8000_0000_0000_0001);
      for (int i = 0; i < 31; i++) step64(2'b10, 64'h0);
      chk("w64_cnt31",  64'(cnt64),  64'd31);
      chk("w64_done31", 64'(done64), 64'h0);
      step64(2'b10, 64'h0);
      chk("w64_data", dout64, 64'hFFFF_FFFF_8000_0000);
      chk("w64_done", 64'(done64), 64'h1);
      chk("w64_sout", 64'(sout64), 64'h0);
      step64(2'b10, 64'h0);
      chk("w64_sat", dout64, 64'hFFFF_FFFF_8000_0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_register_shift_n

// File: doc/register_shift_n.md
# register_shift_n

Parametrised successor to the fixed 64-bit storage register: a WIDTH-bit register with four operating modes (hold, parallel load, arithmetic shift right, shift left). It also has a saturating shift-step counter and a done flag. It sits in the processor's multiply/divide datapath as the product/remainder register: the sequencer loads an operand once, issues one shift per iteration, and uses `done` to tell when STEPS iterations have completed.

## Interface
Parameters:
- WIDTH, 64, register width in bits; must be ≥ 2.
- STEPS, 32, shifts allowed per load before `done` asserts; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock; the block's single clock.
- reset  input  1  asynchronous, active-low reset.
- mode  input  2  operation select: 00 hold, 01 load, 10 shift right arithmetic, 11 shift left.
- data_writeReg  input  WIDTH  parallel load value.
- serial_in  input  1  bit shifted into the LSB on a shift left; ignored otherwise.
- data_readReg  output  WIDTH  current register contents.
- serial_out  output  1  bit shifted out by the most recent accepted shift.
- shift_count  output  $clog2(STEPS+1)  shifts accepted since the last load.
- done  output  1  high when shift_count == STEPS.

## Operation
- Reset values (while `reset` is 0, asynchronously): data_readReg = 0, serial_out = 0, shift_count = 0, done = 0.
- Hold (00): all state is unchanged.
- Load (01):
  - data_readReg ← data_writeReg.
  - shift_count ← 0; serial_out ← 0.
  - Load is accepted regardless of `done`.
- Shift right arithmetic (10), accepted only when done = 0:
  - data_readReg ← {MSB, data_readReg[WIDTH-1:1]}.
  - serial_out ← old bit 0.
  - shift_count increments by 1.
- Shift left (11), accepted only when done = 0:
  - data_readReg ← {data_readReg[WIDTH-2:0], fill}, where fill = serial_in (see Configuration).
  - serial_out ← old MSB.
  - shift_count increments by 1.
- Shift while done = 1: the shift is ignored. Data, serial_out and count hold; the count saturates at STEPS and never wraps.
- done is a pure decode of the registered shift_count (shift_count == STEPS). It adds no extra state and no extra latency.

## Timing
- All state updates on the rising edge of clk. Results are visible on outputs one cycle after the mode is sampled.
- Load-to-done latency: exactly STEPS accepted shift cycles after the load edge. Hold cycles in between do not advance the count.
- Back-to-back shifts are accepted every cycle; there is no bubble.
- Reset mid-operation clears everything immediately, with no clock needed. The first edge after release samples `mode` normally.
- mode is sampled once per edge. There are no multi-cycle handshakes.

## Configuration
- Macro: REGISTER_SHIFT_ROTATE_EN.
- Defined: shift left (11) is a rotate. fill = old MSB, serial_in is ignored, and serial_out still reports the old MSB.
- Undefined: shift left is a logical shift with fill = serial_in.
- Shift right is arithmetic in both builds.

## Structure
- Shared package `register_shift_pkg` holds:
  - mode encodings: MODE_HOLD = 2'b00, MODE_LOAD = 2'b01, MODE_SRA = 2'b10, MODE_SL = 2'b11;
  - a typedef for the 2-bit mode.
- Sub-module `shift_step_counter`: parametrised by STEPS; inputs clk, reset, clr (load), inc (accepted shift); outputs count and done. The top block owns the data path and serial_out.

## Test plan
Unless stated otherwise, WIDTH = 8 and STEPS = 4.
- Reset then hold → data_readReg = 0x00, serial_out = 0, shift_count = 0, done = 0.
- Load 0x96, then one SRA → data_readReg = 0xCB, serial_out = 0, shift_count = 1.
- Load 0x96, then shift left with serial_in = 0:
  - macro undefined → 0x2C, serial_out = 1;
  - macro defined → 0x2D, serial_out = 1.
- Load 0x81, then four SRA → 0xF8, done = 1. A fifth SRA leaves 0xF8 with count 4. A load of 0x05 then gives count = 0, done = 0.
- Load 0x96, two SRA, then assert reset between edges → outputs become 0 immediately, before the next clock edge.
- WIDTH = 64, STEPS = 32: load 0x8000_0000_0000_0001, then 32 SRA → 0xFFFF_FFFF_8000_0000, done = 1 on the edge of the 32nd shift.
